// File: rtl/sr_cond_pkg.sv
// Shared encodings and sizing helper for the set/reset input conditioner.
// Pure declarations: no latency, no backpressure.
package sr_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_HIGH     = 2'd2,
    ST_FALL_CHK = 2'd3
  } deb_state_e;

  localparam int DEBOUNCE_DEFAULT = 4;

  // Counter must be able to hold the value DEBOUNCE_CYCLES itself.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sr_input_conditioner_if.sv
// Raw request lines in, conditioned latch pulses and levels out.
// Wires only: no latency, no backpressure.
interface sr_input_conditioner_if;

  logic set_raw;
  logic reset_raw;
  logic S;
  logic R;
  logic set_level;
  logic reset_level;
  logic conflict;

  modport master (
    output set_raw, reset_raw,
    input  S, R, set_level, reset_level, conflict
  );

  modport slave (
    input  set_raw, reset_raw,
    output S, R, set_level, reset_level, conflict
  );

endinterface

// File: rtl/sr_debounce_ch.sv
// One channel: optional 2-flop synchroniser (SR_COND_SYNC_EN), debounce FSM, rise event.
// Accepts a change after DEBOUNCE_CYCLES stable cycles (+2 with sync); no backpressure.
module sr_debounce_ch
  import sr_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LIM = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic din;

`ifdef SR_COND_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign din = sync2_q;
`else
  assign din = raw_i;
`endif

  deb_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A level change on the input takes priority over the count reaching its limit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (din) begin
          state_d = ST_RISE_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      ST_RISE_CHK: begin
        if (!din) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIM) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          rise_o  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!din) begin
          state_d = ST_FALL_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      ST_FALL_CHK: begin
        if (din) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIM) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = (state_q == ST_HIGH) || (state_q == ST_FALL_CHK);

endmodule

// File: rtl/sr_input_conditioner.sv
// Arbitrates two debounced channels into exclusive one-cycle S/R pulses (SR_COND_SYNC_EN adds sync).
// Pulse/level latency DEBOUNCE_CYCLES edges (+2 with sync); no backpressure.
module sr_input_conditioner
  import sr_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sr_input_conditioner_if.slave  bus
);

  logic set_rise, reset_rise;
  logic set_lvl, reset_lvl;

  sr_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_ch (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (bus.set_raw),
    .level_o (set_lvl),
    .rise_o  (set_rise)
  );

  sr_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_ch (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (bus.reset_raw),
    .level_o (reset_lvl),
    .rise_o  (reset_rise)
  );

  logic s_q, s_d;
  logic r_q, r_d;
  logic conflict_q, conflict_d;

  // Simultaneous acceptance drops both pulses so S=R=1 can never reach the latch.
  always_comb begin
    s_d        = set_rise & ~reset_rise;
    r_d        = reset_rise & ~set_rise;
    conflict_d = set_rise & reset_rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.S           = s_q;
  assign bus.R           = r_q;
  assign bus.conflict    = conflict_q;
  assign bus.set_level   = set_lvl;
  assign bus.reset_level = reset_lvl;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Directed-vector bench for sr_input_conditioner with DEBOUNCE_CYCLES=4.
// Edge e is the e-th rising edge after reset release; outputs are sampled 1ns after it.
module tb_sr_input_conditioner;

  localparam int D = 4;
`ifdef SR_COND_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int PK = D + LAT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sr_input_conditioner_if bus();

  sr_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input int e, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e,
                         input logic s, input logic r, input logic sl,
                         input logic rl, input logic c);
    chk({tag, ".S"},           e, bus.S,           s);
    chk({tag, ".R"},           e, bus.R,           r);
    chk({tag, ".set_level"},   e, bus.set_level,   sl);
    chk({tag, ".reset_level"}, e, bus.reset_level, rl);
    chk({tag, ".conflict"},    e, bus.conflict,    c);
    chk({tag, ".S&R"},         e, bus.S & bus.R,   1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r);
    bus.set_raw   = s;
    bus.reset_raw = r;
  endtask

  // Reset is asserted between edges, so every output must clear without a clock.
  task automatic do_reset();
    drive(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("reset", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0);

    // Held set request: single S pulse, level stays.
    do_reset();
    for (int e = 0; e <= PK + 3; e++) begin
      drive(1'b1, 1'b0);
      tick();
      chk_all("hold", e, e == PK, 1'b0, e >= PK, 1'b0, 1'b0);
    end

    // Raw high for h cycles: 3 and D are rejected, D+1 accepted.
    for (int k = 0; k < 3; k++) begin
      int h;
      h = (k == 0) ? 3 : (k == 1) ? D : D + 1;
      do_reset();
      for (int e = 0; e <= PK + D + 6; e++) begin
        drive(e < h, 1'b0);
        tick();
        chk_all($sformatf("glitch%0d", h), e,
                (h > D) && (e == PK), 1'b0,
                (h > D) && (e >= PK) && (e < h + LAT + D), 1'b0, 1'b0);
      end
    end

    // Both together; stop right at the conflict pulse so the next reset must clear it.
    do_reset();
    for (int e = 0; e <= PK; e++) begin
      drive(1'b1, 1'b1);
      tick();
      chk_all("both", e, 1'b0, 1'b0, e >= PK, e >= PK, e == PK);
    end

    // Reset request one cycle behind set.
    do_reset();
    for (int e = 0; e <= PK + 4; e++) begin
      drive(1'b1, e >= 1);
      tick();
      chk_all("stagger", e, e == PK, e == PK + 1, e >= PK, e >= PK + 1, 1'b0);
    end

    // Reset pulse between edges 3 and 4 while set is mid rise-check.
    do_reset();
    for (int e = 0; e <= PK + 8; e++) begin
      drive(1'b1, 1'b0);
      tick();
      if (e == 3) begin
        rst_n = 1'b0;
        #1;
        chk_all("rst_mid_in", e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
      end else begin
        chk_all("rst_mid", e, e == PK + 4, 1'b0, e >= PK + 4, 1'b0, 1'b0);
      end
    end

    // Press, release for rel cycles from edge 10, press again.
    for (int k = 0; k < 2; k++) begin
      int  rel;
      logic sec;
      rel = (k == 0) ? 3 : 5;
      sec = rel > D;
      do_reset();
      for (int e = 0; e <= 10 + rel + PK + 3; e++) begin
        drive(!((e >= 10) && (e < 10 + rel)), 1'b0);
        tick();
        chk_all($sformatf("repress%0d", rel), e,
                (e == PK) || (sec && (e == 10 + rel + PK)), 1'b0,
                sec ? (((e >= PK) && (e < 10 + PK)) || (e >= 10 + rel + PK)) : (e >= PK),
                1'b0, 1'b0);
      end
    end

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
